// File: rtl/imem_dmem_loader_if.sv
// Host-to-loader word stream: valid/ready handshake carrying 32-bit words
// plus an end-of-transfer marker.
interface imem_dmem_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/imem_dmem_loader.sv
// Boot-time image loader: parses header/payload words from the host stream,
// writes them into imem/dmem external ports, then releases the cpu.
module imem_dmem_loader #(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 10,
  parameter int CNT_W   = 10
) (
  input  logic                 clk,
  input  logic                 srst,
  imem_dmem_loader_if.slave    host,
  output logic [31:0]          addr_ext,
  output logic                 wen_ext,
  output logic [31:0]          wdata_ext,
  output logic [31:0]          addr_ext_2,
  output logic                 wen_ext_2,
  output logic [31:0]          wdata_ext_2,
  output logic                 cpu_enable,
  output logic                 busy,
  output logic                 err,
  input  logic                 reload
);

  localparam int IW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
  localparam logic [IW-1:0] IMEM_MASK = {IW{1'b1}} >> (IW - IMEM_AW);
  localparam logic [IW-1:0] DMEM_MASK = {IW{1'b1}} >> (IW - DMEM_AW);

  typedef enum logic [1:0] {HDR, DATA, RUN} state_t;

  state_t           state;
  logic             ready_q;
  logic             tgt;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] cnt;

  logic             hs;
  logic [IW-1:0]    hdr_mask;
  logic [IW-1:0]    base_idx;
  logic [IW-1:0]    cur_mask;
  logic [31:0]      wr_addr;
  logic             unused_hdr_bits;

  assign host.s_ready    = ready_q;
  assign hs              = host.s_valid && ready_q;
  assign unused_hdr_bits = ^{host.s_data[29:26], host.s_data[15:CNT_W]};

  // Base index is masked to the target memory's width at latch time so the
  // running index always stays within the selected memory.
  always_comb begin
    hdr_mask = host.s_data[31] ? DMEM_MASK : IMEM_MASK;
    base_idx = IW'(host.s_data[25:16]) & hdr_mask;
    cur_mask = tgt ? DMEM_MASK : IMEM_MASK;
    wr_addr  = 32'({idx, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= HDR;
      ready_q     <= 1'b1;
      cpu_enable  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      wen_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      tgt         <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      case (state)
        HDR: begin
          if (hs) begin
            if (host.s_data[30]) begin
              state      <= RUN;
              ready_q    <= 1'b0;
              cpu_enable <= 1'b1;
            end else if (host.s_last) begin
              err <= 1'b1;
            end else if (host.s_data[CNT_W-1:0] != '0) begin
              tgt   <= host.s_data[31];
              idx   <= base_idx;
              cnt   <= host.s_data[CNT_W-1:0];
              busy  <= 1'b1;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (hs) begin
            if (tgt) begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= wr_addr;
              wdata_ext_2 <= host.s_data;
            end else begin
              wen_ext   <= 1'b1;
              addr_ext  <= wr_addr;
              wdata_ext <= host.s_data;
            end
            idx <= (idx + IW'(1)) & cur_mask;
            cnt <= cnt - CNT_W'(1);
            // A stray s_last still commits its word but aborts the section.
            if (cnt == CNT_W'(1) || host.s_last) begin
              state <= HDR;
              busy  <= 1'b0;
            end
            if (host.s_last) begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (reload) begin
            state      <= HDR;
            cpu_enable <= 1'b0;
            err        <= 1'b0;
            ready_q    <= 1'b1;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_loader.sv
// Self-checking bench for imem_dmem_loader: directed table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_imem_dmem_loader;

  logic        clk = 1'b0;
  logic        srst;
  logic        reload;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, wen_ext_2, cpu_enable, busy, err;

  int checks = 0;
  int passed = 0;

  imem_dmem_loader_if host ();

  imem_dmem_loader dut (
    .clk         (clk),
    .srst        (srst),
    .host        (host),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
    .err         (err),
    .reload      (reload)
  );

  always #5 clk = ~clk;

  // Model: m_left == 0 means "expecting a header"; m_cpu means image released.
  bit          m_ready, m_cpu, m_busy, m_err, m_wen, m_wen2, m_tgt;
  logic [31:0] m_addr, m_wdata, m_addr2, m_wdata2;
  int          m_left, m_word;

  function void model_step(bit v, logic [31:0] d, bit l, bit rl, bit rs);
    int mem_words;
    if (rs) begin
      m_ready = 1; m_cpu = 0; m_busy = 0; m_err = 0; m_wen = 0; m_wen2 = 0;
      m_addr = 0; m_wdata = 0; m_addr2 = 0; m_wdata2 = 0;
      m_left = 0; m_word = 0; m_tgt = 0;
      return;
    end
    m_wen  = 0;
    m_wen2 = 0;
    if (m_cpu) begin
      if (rl) begin
        m_cpu = 0; m_ready = 1; m_err = 0;
      end
    end else if (v) begin
      if (m_left == 0) begin
        if (d[30]) begin
          m_cpu = 1; m_ready = 0;
        end else if (l) begin
          m_err = 1;
        end else if (d[9:0] != 0) begin
          m_left = int'(d[9:0]); m_tgt = d[31]; m_word = int'(d[25:16]); m_busy = 1;
        end
      end else begin
        mem_words = m_tgt ? 1024 : 512;
        if (m_tgt) begin
          m_wen2 = 1; m_addr2 = 32'((m_word % mem_words) * 4); m_wdata2 = d;
        end else begin
          m_wen = 1; m_addr = 32'((m_word % mem_words) * 4); m_wdata = d;
        end
        m_word++;
        m_left--;
        if (l) begin
          m_err = 1; m_left = 0;
        end
        if (m_left == 0) m_busy = 0;
      end
    end
  endfunction

  task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(string name);
    logic [133:0] act, exp;
    act = {host.s_ready, cpu_enable, busy, err, wen_ext, wen_ext_2,
           addr_ext, wdata_ext, addr_ext_2, wdata_ext_2};
    exp = {m_ready, m_cpu, m_busy, m_err, m_wen, m_wen2,
           m_addr, m_wdata, m_addr2, m_wdata2};
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL model %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(bit v, logic [31:0] d, bit l, bit rl, bit rs, string name);
    host.s_valid = v;
    host.s_data  = d;
    host.s_last  = l;
    reload       = rl;
    srst         = rs;
    @(posedge clk);
    model_step(v, d, l, rl, rs);
    #1;
    checkOutput(name);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          l;
    bit          rl;
    bit          exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          exp_wen2;
    bit          exp_cpu;
    bit          exp_ready;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] d;
    bit v, l, rl, rs;

    tbl.push_back('{1, 32'h0000_0003, 0, 0, 0, 32'h0, 32'h0,          0, 0, 1, 0});
    tbl.push_back('{1, 32'hA1A1_A1A1, 0, 0, 1, 32'h0, 32'hA1A1_A1A1, 0, 0, 1, 0});
    tbl.push_back('{1, 32'hB2B2_B2B2, 0, 0, 1, 32'h4, 32'hB2B2_B2B2, 0, 0, 1, 0});
    tbl.push_back('{1, 32'hC3C3_C3C3, 0, 0, 1, 32'h8, 32'hC3C3_C3C3, 0, 0, 1, 0});
    tbl.push_back('{0, 32'h0000_0000, 0, 0, 0, 32'h8, 32'hC3C3_C3C3, 0, 0, 1, 0});
    tbl.push_back('{1, 32'h4000_0000, 1, 0, 0, 32'h8, 32'hC3C3_C3C3, 0, 1, 0, 0});
    tbl.push_back('{1, 32'h1234_5678, 0, 0, 0, 32'h8, 32'hC3C3_C3C3, 0, 1, 0, 0});
    tbl.push_back('{0, 32'h0000_0000, 0, 1, 0, 32'h8, 32'hC3C3_C3C3, 0, 0, 1, 0});
    tbl.push_back('{0, 32'h0000_0000, 0, 0, 0, 32'h8, 32'hC3C3_C3C3, 0, 0, 1, 0});

    host.s_valid = 0; host.s_data = 0; host.s_last = 0; reload = 0; srst = 1;
    applyStimulus(0, 0, 0, 0, 1, "reset0");
    applyStimulus(0, 0, 0, 0, 1, "reset1");
    applyStimulus(0, 0, 0, 0, 0, "idle");
    check_eq("reset_ready_cpu_busy_err", {28'h0, host.s_ready, cpu_enable, busy, err}, 32'h8);
    check_eq("reset_wen", {30'h0, wen_ext, wen_ext_2}, 32'h0);

    // Directed table: imem section A,B,C then release and reload.
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rl, 0, $sformatf("tbl%0d", i));
      checks++;
      if ({wen_ext, addr_ext, wdata_ext, wen_ext_2, cpu_enable, host.s_ready, err} ===
          {tbl[i].exp_wen, tbl[i].exp_addr, tbl[i].exp_wdata, tbl[i].exp_wen2,
           tbl[i].exp_cpu, tbl[i].exp_ready, tbl[i].exp_err})
        passed++;
      else
        $display("[TB] FAIL table row %0d: got wen=%0b addr=%0h wdata=%0h wen2=%0b cpu=%0b rdy=%0b err=%0b required wen=%0b addr=%0h wdata=%0h",
                 i, wen_ext, addr_ext, wdata_ext, wen_ext_2, cpu_enable, host.s_ready, err,
                 tbl[i].exp_wen, tbl[i].exp_addr, tbl[i].exp_wdata);
    end

    // Dmem section with a two-cycle valid gap.
    applyStimulus(1, 32'h8005_0002, 0, 0, 0, "dm_hdr");
    check_eq("dm_busy", {31'h0, busy}, 32'h1);
    applyStimulus(1, 32'hDDDD_0001, 0, 0, 0, "dm_d");
    check_eq("dm_d_addr", addr_ext_2, 32'h14);
    check_eq("dm_d_wen", {30'h0, wen_ext, wen_ext_2}, 32'h1);
    applyStimulus(0, 32'h0, 0, 0, 0, "dm_gap0");
    check_eq("dm_gap_wen", {30'h0, wen_ext, wen_ext_2}, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 0, "dm_gap1");
    applyStimulus(1, 32'hEEEE_0002, 0, 0, 0, "dm_e");
    check_eq("dm_e_addr", addr_ext_2, 32'h18);
    check_eq("dm_e_data", wdata_ext_2, 32'hEEEE_0002);

    // Imem wrap at the top of the 9-bit index space.
    applyStimulus(1, 32'h01FF_0002, 0, 0, 0, "wr_hdr");
    applyStimulus(1, 32'h5555_0000, 0, 0, 0, "wr_w0");
    check_eq("wrap_addr_top", addr_ext, 32'h7FC);
    applyStimulus(1, 32'h5555_0001, 0, 0, 0, "wr_w1");
    check_eq("wrap_addr_zero", addr_ext, 32'h0);
    check_eq("wrap_busy_done", {31'h0, busy}, 32'h0);

    // Stray s_last mid-section: two writes, sticky err, back to header.
    applyStimulus(1, 32'h0010_0004, 0, 0, 0, "er_hdr");
    applyStimulus(1, 32'h7777_0000, 0, 0, 0, "er_w0");
    applyStimulus(1, 32'h7777_0001, 1, 0, 0, "er_w1");
    check_eq("err_addr", addr_ext, 32'h44);
    check_eq("err_flags", {29'h0, err, busy, wen_ext}, 32'h5);
    applyStimulus(0, 32'h0, 0, 0, 0, "er_idle");
    applyStimulus(1, 32'h4000_0000, 1, 0, 0, "er_end");
    check_eq("err_run", {29'h0, cpu_enable, err, host.s_ready}, 32'h6);
    applyStimulus(0, 32'h0, 0, 1, 0, "er_reload");
    check_eq("reload_clears", {29'h0, cpu_enable, err, host.s_ready}, 32'h1);

    // Header-level error, then srst on an accepted DATA word.
    applyStimulus(1, 32'h0000_0001, 1, 0, 0, "hdr_err");
    check_eq("hdr_err", {30'h0, err, busy}, 32'h2);
    applyStimulus(1, 32'h8000_0003, 0, 0, 0, "rs_hdr");
    applyStimulus(1, 32'h9999_0000, 0, 0, 0, "rs_w0");
    applyStimulus(1, 32'h9999_0001, 0, 0, 1, "rs_w1");
    check_eq("srst_flags", {27'h0, wen_ext, wen_ext_2, busy, err, host.s_ready}, 32'h1);
    applyStimulus(0, 32'h0, 0, 0, 0, "rs_idle");

    // Randomized run against the model.
    for (int n = 0; n < 600; n++) begin
      d  = $urandom;
      rs = ($urandom_range(99) == 0);
      rl = 0;
      l  = 0;
      v  = ($urandom_range(3) != 0);
      if (m_cpu) begin
        rl = ($urandom_range(3) == 0);
      end else if (m_left == 0) begin
        d[30]  = ($urandom_range(11) == 0);
        d[9:0] = 10'($urandom_range(5));
        l      = d[30] ? bit'($urandom_range(1)) : ($urandom_range(24) == 0);
      end else begin
        l  = ($urandom_range(29) == 0);
        rl = ($urandom_range(9) == 0);
      end
      applyStimulus(v, d, l, rl, rs, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
